// File: rtl/hadamard_cvt_seq.sv
// Sequencer that feeds one block of fixed-point lanes, one lane per cycle, through a
// shared fixed-to-SFP converter and presents the collected SFP words as one block.
module hadamard_cvt_seq #(
    parameter int expWidth    = 4,
    parameter int sigWidth    = 4,
    parameter int formatWidth = 9,
    parameter int low_expand  = 2,
    parameter int LANES       = 4,
    localparam int FW         = sigWidth + 4 + low_expand
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*FW-1:0]          in_fix,
    input  logic [expWidth-1:0]          in_max_exp,
    output logic [FW-1:0]                cvt_fixin,
    output logic [expWidth-1:0]          cvt_max_exp,
    input  logic [formatWidth-1:0]       cvt_sfpout,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*formatWidth-1:0] out_sfp,
    output logic [LANES-1:0]             out_zero_mask,
    output logic [15:0]                  blk_cnt
);

    localparam int LCW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LCW-1:0] LAST = LCW'(LANES - 1);

    typedef enum logic [1:0] {IDLE, CONV, OUT} state_t;

    state_t               state, state_nxt;
    logic [LCW-1:0]       lane_cnt;
    logic [FW-1:0]        lane_q [LANES];
    logic [expWidth-1:0]  max_exp_q;
    logic [FW-1:0]        cur_lane;
    logic                 accept, capture, deliver;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // clr overrides every transition, so handshakes are suppressed while it is high
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        deliver   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid && !clr) begin
                    accept    = 1'b1;
                    state_nxt = CONV;
                end
            end
            CONV: begin
                capture = !clr;
                if (lane_cnt == LAST) state_nxt = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready && !clr) begin
                    deliver   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (clr) state_nxt = IDLE;
    end

    always_comb begin
        cur_lane = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (LCW'(i) == lane_cnt) cur_lane = lane_q[i];
        end
    end

    assign cvt_fixin   = (state == CONV) ? cur_lane : '0;
    assign cvt_max_exp = max_exp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_cnt      <= '0;
            max_exp_q     <= '0;
            out_sfp       <= '0;
            out_zero_mask <= '0;
            blk_cnt       <= '0;
            for (int unsigned i = 0; i < LANES; i++) lane_q[i] <= '0;
        end else if (clr) begin
            lane_cnt <= '0;
        end else begin
            if (accept) begin
                lane_cnt  <= '0;
                max_exp_q <= in_max_exp;
                for (int unsigned i = 0; i < LANES; i++) lane_q[i] <= in_fix[i*FW +: FW];
            end
            if (capture) begin
                for (int unsigned i = 0; i < LANES; i++) begin
                    if (LCW'(i) == lane_cnt) begin
                        out_sfp[i*formatWidth +: formatWidth] <= cvt_sfpout;
                        out_zero_mask[i] <= (cur_lane[FW-2:0] == '0);
                    end
                end
                lane_cnt <= (lane_cnt == LAST) ? '0 : lane_cnt + LCW'(1);
            end
            if (deliver) blk_cnt <= blk_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_hadamard_cvt_seq.sv
// Directed-vector bench for hadamard_cvt_seq: a scoreboard queue of hand-computed blocks
// is drained by a monitor on each output handshake; control behaviour is checked inline.
module tb_hadamard_cvt_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [39:0] in_fix = '0;
    logic [3:0]  in_max_exp = '0;
    logic        in_ready, out_valid;
    logic [9:0]  cvt_fixin;
    logic [3:0]  cvt_max_exp;
    logic [8:0]  cvt_sfpout;
    logic [35:0] out_sfp;
    logic [3:0]  out_zero_mask;
    logic [15:0] blk_cnt;

    typedef struct packed {
        logic [35:0] sfp;
        logic [3:0]  mask;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned err_cnt = 0;
    int unsigned chk_cnt = 0;

    always #5 clk = ~clk;

    assign cvt_sfpout = {1'b0, cvt_max_exp, cvt_fixin[3:0]};

    hadamard_cvt_seq #(
        .expWidth(4), .sigWidth(4), .formatWidth(9), .low_expand(2), .LANES(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_fix(in_fix), .in_max_exp(in_max_exp),
        .cvt_fixin(cvt_fixin), .cvt_max_exp(cvt_max_exp), .cvt_sfpout(cvt_sfpout),
        .out_valid(out_valid), .out_ready(out_ready), .out_sfp(out_sfp),
        .out_zero_mask(out_zero_mask), .blk_cnt(blk_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        chk_cnt++;
        if (act !== req) begin
            err_cnt++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns one cycle after acceptance, with the DUT in CONV at lane 0
    task automatic offer(input logic [39:0] fix, input logic [3:0] e,
                         input logic [35:0] sfp, input logic [3:0] mask, input bit push);
        int unsigned n = 0;
        while (!in_ready && n < 50) begin step(); n++; end
        if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
        in_valid   = 1'b1;
        in_fix     = fix;
        in_max_exp = e;
        if (push) sb_q.push_back('{sfp: sfp, mask: mask});
        step();
        in_valid = 1'b0;
    endtask

    task automatic conv_walk(input logic [39:0] fix, input logic [3:0] e);
        for (int i = 0; i < 4; i++) begin
            chk("cvt_fixin", 64'(cvt_fixin), 64'(fix[i*10 +: 10]));
            chk("cvt_max_exp", 64'(cvt_max_exp), 64'(e));
            chk("no_early_valid", 64'(out_valid), 64'd0);
            step();
        end
        chk("out_valid_latency", 64'(out_valid), 64'd1);
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        while (!in_ready && n < 50) begin step(); n++; end
        if (!in_ready) chk("idle_timeout", 64'(in_ready), 64'd1);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !clr) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_block", 64'(out_sfp), 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("out_sfp", 64'(out_sfp), 64'(e.sfp));
                chk("out_zero_mask", 64'(out_zero_mask), 64'(e.mask));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // reset values
        #1 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_sfp", 64'(out_sfp), 64'd0);
        chk("rst_zero_mask", 64'(out_zero_mask), 64'd0);
        chk("rst_blk_cnt", 64'(blk_cnt), 64'd0);
        chk("rst_cvt_fixin", 64'(cvt_fixin), 64'd0);
        chk("rst_cvt_max_exp", 64'(cvt_max_exp), 64'd0);
        step(); step();
        rst_n = 1'b1;
        step();

        // single block
        offer({10'h004, 10'h003, 10'h002, 10'h001}, 4'h5,
              {9'h054, 9'h053, 9'h052, 9'h051}, 4'b0000, 1'b1);
        conv_walk({10'h004, 10'h003, 10'h002, 10'h001}, 4'h5);
        wait_idle();
        chk("blk_cnt_1", 64'(blk_cnt), 64'd1);
        chk("idle_cvt_fixin", 64'(cvt_fixin), 64'd0);
        chk("idle_cvt_max_exp_hold", 64'(cvt_max_exp), 64'h5);

        // zero mask: sign-only and zero lanes flagged
        offer({10'h001, 10'h3FF, 10'h000, 10'h200}, 4'h3,
              {9'h031, 9'h03F, 9'h030, 9'h030}, 4'b0011, 1'b1);
        conv_walk({10'h001, 10'h3FF, 10'h000, 10'h200}, 4'h3);
        wait_idle();
        chk("blk_cnt_2", 64'(blk_cnt), 64'd2);

        // backpressure with a competing block offered
        out_ready = 1'b0;
        offer({10'h13C, 10'h2C3, 10'h15A, 10'h0A5}, 4'hC,
              {9'h0CC, 9'h0C3, 9'h0CA, 9'h0C5}, 4'b0000, 1'b1);
        conv_walk({10'h13C, 10'h2C3, 10'h15A, 10'h0A5}, 4'hC);
        in_valid   = 1'b1;
        in_fix     = {10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF};
        in_max_exp = 4'h9;
        for (int i = 0; i < 10; i++) begin
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_out_sfp", 64'(out_sfp), 64'({9'h0CC, 9'h0C3, 9'h0CA, 9'h0C5}));
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        chk("blk_cnt_3", 64'(blk_cnt), 64'd3);
        chk("bp_no_relatch", 64'(cvt_max_exp), 64'hC);

        // clr at lane 2 aborts the block
        offer({10'h111, 10'h122, 10'h133, 10'h144}, 4'h2, '0, '0, 1'b0);
        step(); step();
        chk("clr_lane2", 64'(cvt_fixin), 64'h122);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_in_ready", 64'(in_ready), 64'd1);
        chk("clr_blk_cnt", 64'(blk_cnt), 64'd3);
        for (int i = 0; i < 6; i++) begin
            chk("clr_no_valid", 64'(out_valid), 64'd0);
            step();
        end
        offer({10'h200, 10'h080, 10'h1F0, 10'h00F}, 4'h7,
              {9'h070, 9'h070, 9'h070, 9'h07F}, 4'b1000, 1'b1);
        conv_walk({10'h200, 10'h080, 10'h1F0, 10'h00F}, 4'h7);
        wait_idle();
        chk("blk_cnt_4", 64'(blk_cnt), 64'd4);

        // asynchronous reset mid-CONV
        offer({10'h0AA, 10'h0BB, 10'h0CC, 10'h0DD}, 4'hE, '0, '0, 1'b0);
        step();
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_out_sfp", 64'(out_sfp), 64'd0);
        chk("arst_zero_mask", 64'(out_zero_mask), 64'd0);
        chk("arst_blk_cnt", 64'(blk_cnt), 64'd0);
        chk("arst_cvt_fixin", 64'(cvt_fixin), 64'd0);
        chk("arst_cvt_max_exp", 64'(cvt_max_exp), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("arst_release_ready", 64'(in_ready), 64'd1);

        // blk_cnt wrap: counter preloaded as if 65535 blocks had completed
        force dut.blk_cnt = 16'hFFFF;
        step();
        release dut.blk_cnt;
        chk("wrap_preload", 64'(blk_cnt), 64'hFFFF);
        offer({10'h001, 10'h001, 10'h001, 10'h001}, 4'h1,
              {9'h011, 9'h011, 9'h011, 9'h011}, 4'b0000, 1'b1);
        conv_walk({10'h001, 10'h001, 10'h001, 10'h001}, 4'h1);
        wait_idle();
        chk("blk_cnt_wrap", 64'(blk_cnt), 64'h0000);

        step(); step();
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
